// File: rtl/lsu_bus_ctrl_pkg.sv
// lsu_bus_ctrl shared definitions: RV32I load/store funct3 codes
// and controller FSM state encoding.
package lsu_bus_ctrl_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, lane-replicated store data and
// illegal/misaligned detection for one load/store request.
module lsu_align
   import lsu_bus_ctrl_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic        o_illegal
);

   // 0 = byte, 1 = half, 2 = word, 3 = not a legal encoding
   logic [1:0] w_size;

   // classify the access width from direction and funct3
   always_comb begin
      w_size = 2'd3;
      if (i_we) begin
         case (i_funct3)
            F3_SB:   w_size = 2'd0;
            F3_SH:   w_size = 2'd1;
            F3_SW:   w_size = 2'd2;
            default: w_size = 2'd3;
         endcase
      end else begin
         case (i_funct3)
            F3_LB, F3_LBU: w_size = 2'd0;
            F3_LH, F3_LHU: w_size = 2'd1;
            F3_LW:         w_size = 2'd2;
            default:       w_size = 2'd3;
         endcase
      end
   end

   // lane enables, data replication and alignment per width
   always_comb begin
      o_be         = 4'b0000;
      o_wdata      = i_wdata;
      o_misaligned = 1'b0;
      o_illegal    = 1'b0;
      case (w_size)
         2'd0: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         2'd1: begin
            o_be         = 4'b0011 << i_addr_lo;
            o_wdata      = {2{i_wdata[15:0]}};
            o_misaligned = i_addr_lo[0];
         end
         2'd2: begin
            o_be         = 4'b1111;
            o_misaligned = |i_addr_lo;
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: pipeline load/store to single-beat data bus bridge.
// Optional bus-wait timeout abort enabled by macro LSU_TIMEOUT_EN.
module lsu_bus_ctrl
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [2:0]  rsp_funct3,
   output logic        rsp_load,
   output logic        rsp_err
);

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_rsp_data;
   logic        r_rsp_load;
   logic        r_rsp_err;

   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_mis;
   logic        w_ill;
   logic        w_bad;
   logic        w_accept;
   logic        w_ack;
   logic        w_timeout;

   lsu_align u_align (
      .i_we         (req_we),
      .i_funct3     (req_funct3),
      .i_addr_lo    (req_addr[1:0]),
      .i_wdata      (req_wdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_mis),
      .o_illegal    (w_ill)
   );

   assign w_bad    = w_mis | w_ill;
   assign w_accept = (r_state == ST_IDLE) && req_valid;
   assign w_ack    = (r_state == ST_BUS) && bus_ack;

`ifdef LSU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tcnt;

   // count cycles spent in BUS waiting for ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_tcnt <= '0;
      else if (r_state != ST_BUS) r_tcnt <= '0;
      else                        r_tcnt <= r_tcnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_BUS) && !bus_ack &&
                      (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (req_valid) w_next = w_bad ? ST_RESP : ST_BUS;
         ST_BUS:  if (bus_ack || w_timeout) w_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // capture request on accept, build response on ack/abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we       <= 1'b0;
         r_funct3   <= 3'b000;
         r_addr     <= 32'd0;
         r_be       <= 4'b0000;
         r_wdata    <= 32'd0;
         r_rsp_data <= 32'd0;
         r_rsp_load <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else if (w_accept) begin
         r_we       <= req_we;
         r_funct3   <= req_funct3;
         r_addr     <= req_addr;
         r_be       <= w_be;
         r_wdata    <= w_wdata;
         r_rsp_data <= 32'd0;
         r_rsp_load <= 1'b0;
         r_rsp_err  <= w_bad;
      end else if (w_ack) begin
         r_rsp_data <= r_we ? 32'd0 :
                       (bus_rdata >> {r_addr[1:0], 3'b000});
         r_rsp_load <= !r_we;
         r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
         r_rsp_data <= 32'd0;
         r_rsp_load <= 1'b0;
         r_rsp_err  <= 1'b1;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
         r_rsp_load <= 1'b0;
         r_rsp_err  <= 1'b0;
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign bus_req    = (r_state == ST_BUS);
   assign bus_we     = (r_state == ST_BUS) && r_we;
   assign bus_be     = (r_state == ST_BUS) ? r_be : 4'b0000;
   assign bus_addr   = {r_addr[31:2], 2'b00};
   assign bus_wdata  = r_wdata;
   assign rsp_valid  = (r_state == ST_RESP);
   assign rsp_data   = r_rsp_data;
   assign rsp_funct3 = r_funct3;
   assign rsp_load   = r_rsp_load;
   assign rsp_err    = r_rsp_err;

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus-wait cycles before timeout abort (used only with LSU_TIMEOUT_EN).
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  pipeline memory request valid.
REQ-005 Port: req_ready  out  1  block can accept a request.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  in  3  RV32I load/store funct3.
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  store data from rs2.
REQ-010 Port: bus_req  out  1  data-memory access request.
REQ-011 Port: bus_we  out  1  bus write strobe.
REQ-012 Port: bus_addr  out  32  word address, {req_addr[31:2],2'b00}.
REQ-013 Port: bus_be  out  4  byte enables.
REQ-014 Port: bus_wdata  out  32  lane-replicated store data.
REQ-015 Port: bus_ack  in  1  access complete; bus_rdata valid this cycle.
REQ-016 Port: bus_rdata  in  32  read word.
REQ-017 Port: rsp_valid  out  1  response valid.
REQ-018 Port: rsp_ready  in  1  downstream accepts response.
REQ-019 Port: rsp_data  out  32  right-aligned load data (ReadData of the load extension stage).
REQ-020 Port: rsp_funct3  out  3  latched funct3 for the load extension stage.
REQ-021 Port: rsp_load  out  1  enable for the load extension stage; 1 only for a successful load.
REQ-022 Port: rsp_err  out  1  misaligned, illegal funct3, or timeout.

Function
REQ-023 FSM states IDLE, BUS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-024 IDLE with req_valid: latch we/funct3/addr/wdata; legal and aligned -> BUS; otherwise -> RESP with rsp_err=1, rsp_data=0, no bus access.
REQ-025 Legal funct3: loads 000,001,010,100,101; stores 000,001,010; all others illegal.
REQ-026 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-027 BUS: bus_req=1; bus_we/addr/be/wdata held stable until the cycle bus_ack=1.
REQ-028 Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; loads drive the same enables.
REQ-029 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
REQ-030 On bus_ack: rsp_data = bus_rdata >> (8*addr[1:0]) for loads, 0 for stores; -> RESP; bus_req deasserts the next cycle.
REQ-031 RESP: rsp_valid=1 with stable outputs until rsp_ready=1, then -> IDLE; stores also produce a response (rsp_load=0).
REQ-032 Minimum latency: accepted at edge N, bus_req high in cycle N+1, ack in N+1 gives rsp_valid in cycle N+2; error path gives rsp_valid in N+1.
REQ-033 bus_ack outside BUS SHALL be ignored.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE; bus_req, bus_we, rsp_valid, rsp_load, rsp_err = 0; bus_be = 0; bus_addr, bus_wdata, rsp_data, rsp_funct3 = 0.
REQ-035 Reset mid-BUS or mid-RESP abandons the transaction; no response issued after reset.

Configuration
REQ-036 Macro LSU_TIMEOUT_EN defined: a counter counts BUS cycles without ack; at TIMEOUT_CYCLES, drop bus_req, -> RESP with rsp_err=1, rsp_data=0, rsp_load=0.
REQ-037 Macro not defined: no counter; BUS waits indefinitely; rsp_err only for misaligned or illegal funct3.

Structure
REQ-038 Shared package holds funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and FSM state encodings.
REQ-039 One combinational sub-module lsu_align computes bus_be, replicated wdata, and misalignment/illegal flags.

Verification
REQ-040 SB addr 0x1003, wdata 0x000000AB, ack after 2 cycles -> bus_addr 0x1000, be 4'b1000, wdata 0xABABABAB; rsp_load=0, rsp_err=0.
REQ-041 LH addr 0x2002, bus_rdata 0xBEEF1234, ack same cycle -> rsp_data 0x0000BEEF, rsp_funct3 001, rsp_load=1, rsp_valid in cycle N+2.
REQ-042 LW addr 0x3001 -> no bus_req; rsp_err=1, rsp_data 0 in cycle N+1.
REQ-043 LW with rsp_ready held low for 5 cycles -> rsp outputs stable, req_ready=0 throughout; IDLE after rsp_ready.
REQ-044 rst_n pulsed low during BUS -> bus_req low immediately; no rsp_valid afterwards.
REQ-045 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 BUS cycles, rsp_err=1.
